// File: rtl/fib_pkg.sv
// Shared constants and control encoding for the Fibonacci generator.
// Build option: FIB_SATURATE_EN selects hold-at-max instead of wrap-restart.
package fib_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int FIB_SEED_CUR  = 0;
  localparam int FIB_SEED_NXT  = 1;

  typedef enum logic [1:0] {
    CTRL_HOLD    = 2'd0,
    CTRL_STEP    = 2'd1,
    CTRL_RESTART = 2'd2
  } fib_ctrl_e;

  // Decide what an edge does once reset has been ruled out.
  function automatic fib_ctrl_e fib_ctrl(
    input logic start,
    input logic ovf
  );
    fib_ctrl_e c;
    c = CTRL_HOLD;
    if (start) begin
      if (!ovf) begin
        c = CTRL_STEP;
      end else begin
`ifdef FIB_SATURATE_EN
        c = CTRL_HOLD;
`else
        c = CTRL_RESTART;
`endif
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/fib_adder.sv
// Unsigned WIDTH-bit adder exposing the carry-out.
// Build option: none (FIB_SATURATE_EN is handled by the control logic).
module fib_adder
  import fib_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] full;

  assign full    = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o   = full[WIDTH-1:0];
  assign carry_o = full[WIDTH];

endmodule

// File: rtl/fibonacci_series.sv
// Free-running Fibonacci term generator with registered output.
// Build option: FIB_SATURATE_EN holds F_max on overflow instead of restarting.
module fibonacci_series
  import fib_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] fib_out
);

  localparam logic [WIDTH-1:0] SEED_CUR = WIDTH'(FIB_SEED_CUR);
  localparam logic [WIDTH-1:0] SEED_NXT = WIDTH'(FIB_SEED_NXT);

  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] nxt_q, nxt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sum;
  logic             carry;
  fib_ctrl_e        ctrl;

  fib_adder #(
    .WIDTH   (WIDTH)
  ) u_add (
    .a_i     (cur_q),
    .b_i     (nxt_q),
    .sum_o   (sum),
    .carry_o (carry)
  );

  assign ctrl = fib_ctrl(start, ovf_q);

  always_comb begin
    cur_d = cur_q;
    nxt_d = nxt_q;
    ovf_d = ovf_q;
    unique case (ctrl)
      CTRL_STEP: begin
        cur_d = nxt_q;
        nxt_d = sum;
        ovf_d = carry;
      end
      CTRL_RESTART: begin
        cur_d = SEED_CUR;
        nxt_d = SEED_NXT;
        ovf_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= SEED_CUR;
      nxt_q <= SEED_NXT;
      ovf_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      nxt_q <= nxt_d;
      ovf_q <= ovf_d;
    end
  end

  assign fib_out = cur_q;

endmodule

// File: tb/tb_fibonacci_series.sv
// Directed bench for fibonacci_series at WIDTH=32 and WIDTH=8.
// Expected values follow FIB_SATURATE_EN when it is defined.
module tb_fibonacci_series;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] fib32;
  logic [7:0]  fib8;

  int errors = 0;
  int checks = 0;

  fibonacci_series #(.WIDTH(32)) dut32 (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .fib_out (fib32)
  );

  fibonacci_series #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .fib_out (fib8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for one rising edge, return at the following falling edge.
  task automatic cyc(input logic r, input logic s);
    rst   = r;
    start = s;
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0);
      checks++;
      if (fib32 !== 32'd0) begin
        errors++;
        $display("FAIL reset_%0d: got %0d want 0", i, fib32);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0);
      checks++;
      if (fib32 !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold_%0d: got %0d want 0", i, fib32);
      end
    end
  endtask

  task automatic test_sequence;
    logic [31:0] exp_q[10];
    exp_q = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1);
      checks++;
      if (fib32 !== exp_q[i]) begin
        errors++;
        $display("FAIL seq_%0d: got %0d want %0d", i, fib32, exp_q[i]);
      end
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0);
      checks++;
      if (fib32 !== 32'd55) begin
        errors++;
        $display("FAIL hold_%0d: got %0d want 55", i, fib32);
      end
    end
    cyc(1'b0, 1'b1);
    checks++;
    if (fib32 !== 32'd89) begin
      errors++;
      $display("FAIL resume: got %0d want 89", fib32);
    end
  endtask

  task automatic test_reset_priority;
    logic [31:0] exp_q[3];
    exp_q = '{1, 1, 2};
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1);
    checks++;
    if (fib32 !== 32'd21) begin
      errors++;
      $display("FAIL pre_rst_21: got %0d want 21", fib32);
    end
    cyc(1'b1, 1'b1);
    checks++;
    if (fib32 !== 32'd0) begin
      errors++;
      $display("FAIL rst_prio: got %0d want 0", fib32);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1);
      checks++;
      if (fib32 !== exp_q[i]) begin
        errors++;
        $display("FAIL post_rst_%0d: got %0d want %0d",
                 i, fib32, exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow8;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1);
    checks++;
    if (fib8 !== 8'd144) begin
      errors++;
      $display("FAIL w8_f12: got %0d want 144", fib8);
    end
    cyc(1'b0, 1'b1);
    checks++;
    if (fib8 !== 8'd233) begin
      errors++;
      $display("FAIL w8_fmax: got %0d want 233", fib8);
    end
`ifdef FIB_SATURATE_EN
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1);
      checks++;
      if (fib8 !== 8'd233) begin
        errors++;
        $display("FAIL w8_sat_%0d: got %0d want 233", i, fib8);
      end
    end
`else
    cyc(1'b0, 1'b1);
    checks++;
    if (fib8 !== 8'd0) begin
      errors++;
      $display("FAIL w8_wrap0: got %0d want 0", fib8);
    end
    cyc(1'b0, 1'b1);
    checks++;
    if (fib8 !== 8'd1) begin
      errors++;
      $display("FAIL w8_wrap1: got %0d want 1", fib8);
    end
    cyc(1'b0, 1'b1);
    checks++;
    if (fib8 !== 8'd1) begin
      errors++;
      $display("FAIL w8_wrap2: got %0d want 1", fib8);
    end
`endif
  endtask

  task automatic test_overflow32;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1);
    checks++;
    if (fib32 !== 32'd832040) begin
      errors++;
      $display("FAIL w32_f30: got %0d want 832040", fib32);
    end
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1);
    checks++;
    if (fib32 !== 32'd2971215073) begin
      errors++;
      $display("FAIL w32_f47: got %0d want 2971215073", fib32);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (fib32 !== 32'd2971215073) begin
      errors++;
      $display("FAIL w32_idle: got %0d want 2971215073", fib32);
    end
`ifdef FIB_SATURATE_EN
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1);
      checks++;
      if (fib32 !== 32'd2971215073) begin
        errors++;
        $display("FAIL w32_sat_%0d: got %0d want 2971215073", i, fib32);
      end
    end
`else
    cyc(1'b0, 1'b1);
    checks++;
    if (fib32 !== 32'd0) begin
      errors++;
      $display("FAIL w32_wrap0: got %0d want 0", fib32);
    end
    cyc(1'b0, 1'b1);
    checks++;
    if (fib32 !== 32'd1) begin
      errors++;
      $display("FAIL w32_wrap1: got %0d want 1", fib32);
    end
`endif
    cyc(1'b1, 1'b1);
    checks++;
    if (fib32 !== 32'd0 || fib8 !== 8'd0) begin
      errors++;
      $display("FAIL final_rst: got %0d/%0d want 0/0", fib32, fib8);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    test_reset;
    test_sequence;
    test_hold;
    test_reset_priority;
    test_overflow8;
    test_overflow32;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
